// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: valid/ready config write port of led_pattern_gen
interface led_pattern_gen_if #(
    parameter int CHANNELS = 3,
    parameter int CNT_W = 28,
    parameter int PWM_W = 8
);
    localparam int CHAN_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int TAP_W = $clog2(CNT_W);
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_err;
    logic [CHAN_W-1:0] cfg_chan;
    logic [1:0] cfg_mode;
    logic [TAP_W-1:0] cfg_tap;
    logic [PWM_W-1:0] cfg_duty;
    modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_tap, cfg_duty, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_chan, cfg_mode, cfg_tap, cfg_duty, output cfg_ready, cfg_err);
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel OFF/ON/BLINK/BREATHE LED generator; BREATHE ramp built only with LED_PATTERN_BREATHE_EN
module led_pattern_gen #(
    parameter int CHANNELS = 3,
    parameter int CNT_W = 28,
    parameter int PWM_W = 8
) (
    input  logic clk,
    input  logic rst,
    led_pattern_gen_if.slave cfg,
    output logic [CHANNELS-1:0] led
);
    localparam int TAP_W = $clog2(CNT_W);
    typedef enum logic [1:0] {OFF, ON, BLINK, BREATHE} mode_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] led_q, led_d, prev_q, prev_d;
    logic ready_q, ready_d, err_q, err_d;
    logic accept, hit, on;
    logic [TAP_W-1:0] tap_w;
    mode_e mode_q [CHANNELS];
    mode_e mode_d [CHANNELS];
    logic [TAP_W-1:0] tap_q [CHANNELS];
    logic [TAP_W-1:0] tap_d [CHANNELS];
    logic [PWM_W-1:0] duty_q [CHANNELS];
    logic [PWM_W-1:0] duty_d [CHANNELS];
`ifdef LED_PATTERN_BREATHE_EN
    logic [PWM_W-1:0] ramp_q [CHANNELS];
    logic [PWM_W-1:0] ramp_d [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
`endif
    assign accept = cfg.cfg_valid & ready_q;
    assign hit = accept & (int'(cfg.cfg_chan) < CHANNELS);
    assign tap_w = int'(cfg.cfg_tap) >= CNT_W ? TAP_W'(CNT_W - 1) : cfg.cfg_tap;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err = err_q;
    assign led = led_q;
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        pwm_d = pwm_q + PWM_W'(1);
        ready_d = ~accept;
        err_d = accept & ~hit;
        on = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i] = mode_q[i];
            tap_d[i] = tap_q[i];
            duty_d[i] = duty_q[i];
            prev_d[i] = cnt_q[tap_q[i]];
            on = pwm_q < duty_q[i];
`ifdef LED_PATTERN_BREATHE_EN
            ramp_d[i] = ramp_q[i];
            dir_d[i] = dir_q[i];
            if (mode_q[i] == BREATHE) on = pwm_q < ramp_q[i];
            // each extreme holds one tap step while dir turns around
            if (cnt_q[tap_q[i]] && !prev_q[i]) begin
                dir_d[i] = dir_q[i] ? ramp_q[i] < duty_q[i] : ramp_q[i] == '0;
                ramp_d[i] = dir_q[i] ? (ramp_q[i] < duty_q[i] ? ramp_q[i] + PWM_W'(1) : ramp_q[i])
                                     : (ramp_q[i] != '0 ? ramp_q[i] - PWM_W'(1) : ramp_q[i]);
            end
`endif
            led_d[i] = mode_q[i] == OFF ? 1'b0 : mode_q[i] == BLINK ? cnt_q[tap_q[i]] & on : on;
            if (hit && int'(cfg.cfg_chan) == i) begin
                mode_d[i] = mode_e'(cfg.cfg_mode);
                tap_d[i] = tap_w;
                duty_d[i] = cfg.cfg_duty;
                prev_d[i] = cnt_q[tap_w];
`ifdef LED_PATTERN_BREATHE_EN
                ramp_d[i] = '0;
                dir_d[i] = 1'b1;
`endif
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= '0;
            led_q <= '0;
            prev_q <= '0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i] <= i == 0 ? BLINK : OFF;
                tap_q[i] <= i == 0 ? TAP_W'(CNT_W - 1) : '0;
                duty_q[i] <= i == 0 ? '1 : '0;
`ifdef LED_PATTERN_BREATHE_EN
                ramp_q[i] <= '0;
`endif
            end
`ifdef LED_PATTERN_BREATHE_EN
            dir_q <= '1;
`endif
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
            led_q <= led_d;
            prev_q <= prev_d;
            ready_q <= ready_d;
            err_q <= err_d;
            mode_q <= mode_d;
            tap_q <= tap_d;
            duty_q <= duty_d;
`ifdef LED_PATTERN_BREATHE_EN
            ramp_q <= ramp_d;
            dir_q <= dir_d;
`endif
        end
    end
endmodule
